// File: rtl/movegen_ctrl.sv
// ---------------------------------------------------------------------------
// movegen_ctrl
//
// Drives one capture-ordered move-generation pass against a `board` block.
// The pass works like this:
//   1. Ask the board for the best victim.
//   2. Ask for that victim's attackers one at a time.
//   3. Emit each (attacker -> victim) pair on a valid/ready stream, then mask
//      that attacker.
//   4. When a victim has no attackers left, mask the victim and ask for the
//      next one.
//   5. When no victim is left, the pass ends.
//
// The board answers BOARD_LAT cycles after a command. `board_data` is only
// looked at in the last wait cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, side      begin a pass (only in idle); `side` is latched into wtm
//   abort            return to idle from anywhere; no done pulse
//   busy, done       not-idle flag; one-cycle end-of-pass pulse
//   move_valid/ready move stream handshake
//   move_from/to     attacker / victim square of the offered move
//   move_count       accepted moves this pass, saturating at 255
//   state_mode, mask_mode, wtm, write_bus, ss1*, ss2*   board command bus
//   board_data       board result: [6] found, [5:0] square
//
// Every output is registered. Each output register is loaded from the
// decode of the *next* state, so a command appears on the ports in the same
// cycle that the FSM sits in the state that issues it.
// ---------------------------------------------------------------------------
module movegen_ctrl #(
    parameter int BOARD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       side,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [5:0] move_from,
    output logic [5:0] move_to,
    output logic [7:0] move_count,
    output logic [2:0] state_mode,
    output logic [1:0] mask_mode,
    output logic       wtm,
    output logic [3:0] write_bus,
    output logic [5:0] ss1,
    output logic       ss1_valid,
    output logic [5:0] ss2,
    output logic       ss2_valid,
    input  logic [6:0] board_data
);

    localparam logic [2:0] SM_NOP      = 3'd0;
    localparam logic [2:0] SM_VICTIM   = 3'd1;
    localparam logic [2:0] SM_ATTACKER = 3'd2;
    localparam logic [1:0] MM_NONE     = 2'd0;
    localparam logic [1:0] MM_CLEAR    = 2'd1;
    localparam logic [1:0] MM_VICTIM   = 2'd2;
    localparam logic [1:0] MM_ATTACKER = 2'd3;
    localparam logic [2:0] LAT_LOAD    = 3'(BOARD_LAT);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLEAR  = 4'd1,
        ST_VICTIM = 4'd2,
        ST_VWAIT  = 4'd3,
        ST_ATTACK = 4'd4,
        ST_AWAIT  = 4'd5,
        ST_EMIT   = 4'd6,
        ST_MASK_A = 4'd7,
        ST_MASK_V = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

    state_t     state_r, state_s;
    logic [5:0] victim_r, victim_s;
    logic [5:0] attacker_r, attacker_s;
    logic [2:0] wait_cnt_r, wait_cnt_s;
    logic       wtm_r, wtm_s;
    logic [7:0] move_count_r, move_count_s;

    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       move_valid_r, move_valid_s;
    logic [5:0] move_from_r, move_from_s;
    logic [5:0] move_to_r, move_to_s;
    logic [2:0] state_mode_r, state_mode_s;
    logic [1:0] mask_mode_r, mask_mode_s;
    logic [5:0] ss1_r, ss1_s;
    logic       ss1_valid_r, ss1_valid_s;
    logic [5:0] ss2_r, ss2_s;
    logic       ss2_valid_r, ss2_valid_s;

    // Next-state logic: pass sequencing, board sampling and the move counter.
    always_comb begin
        state_s      = state_r;
        victim_s     = victim_r;
        attacker_s   = attacker_r;
        wait_cnt_s   = wait_cnt_r;
        wtm_s        = wtm_r;
        move_count_s = move_count_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    wtm_s        = side;
                    move_count_s = 8'd0;
                    state_s      = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_VICTIM;
            end
            ST_VICTIM: begin
                wait_cnt_s = LAT_LOAD;
                state_s    = ST_VWAIT;
            end
            ST_VWAIT: begin
                // The counter reaches zero exactly BOARD_LAT cycles after the
                // command cycle. That is when the board answer is valid.
                wait_cnt_s = wait_cnt_r - 3'd1;
                if (wait_cnt_s == 3'd0) begin
                    if (board_data[6]) begin
                        victim_s = board_data[5:0];
                        state_s  = ST_ATTACK;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_VWAIT;
                end
            end
            ST_ATTACK: begin
                wait_cnt_s = LAT_LOAD;
                state_s    = ST_AWAIT;
            end
            ST_AWAIT: begin
                wait_cnt_s = wait_cnt_r - 3'd1;
                if (wait_cnt_s == 3'd0) begin
                    if (board_data[6]) begin
                        attacker_s = board_data[5:0];
                        state_s    = ST_EMIT;
                    end else begin
                        state_s = ST_MASK_V;
                    end
                end else begin
                    state_s = ST_AWAIT;
                end
            end
            ST_EMIT: begin
                if (move_ready) begin
                    if (move_count_r == 8'd255) begin
                        move_count_s = move_count_r;
                    end else begin
                        move_count_s = move_count_r + 8'd1;
                    end
                    state_s = ST_MASK_A;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_MASK_A: begin
                state_s = ST_ATTACK;
            end
            ST_MASK_V: begin
                state_s = ST_VICTIM;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Abort beats every transition. It also cancels a start in idle and
        // a handshake in EMIT, so the latched side and the count keep their
        // current values.
        if (abort) begin
            state_s      = ST_IDLE;
            wtm_s        = wtm_r;
            move_count_s = move_count_r;
        end else begin
            state_s = state_s;
        end
    end

    // Output decode from the next state, ready to be registered.
    always_comb begin
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
        move_valid_s = 1'b0;
        move_from_s  = 6'd0;
        move_to_s    = 6'd0;
        state_mode_s = SM_NOP;
        mask_mode_s  = MM_NONE;
        ss1_s        = 6'd0;
        ss1_valid_s  = 1'b0;
        ss2_s        = 6'd0;
        ss2_valid_s  = 1'b0;

        case (state_s)
            ST_CLEAR: begin
                mask_mode_s = MM_CLEAR;
            end
            ST_VICTIM: begin
                state_mode_s = SM_VICTIM;
            end
            ST_ATTACK: begin
                state_mode_s = SM_ATTACKER;
                ss1_s        = victim_s;
                ss1_valid_s  = 1'b1;
            end
            ST_EMIT: begin
                move_valid_s = 1'b1;
                move_from_s  = attacker_s;
                move_to_s    = victim_s;
            end
            ST_MASK_A: begin
                mask_mode_s = MM_ATTACKER;
                ss1_s       = victim_s;
                ss1_valid_s = 1'b1;
                ss2_s       = attacker_s;
                ss2_valid_s = 1'b1;
            end
            ST_MASK_V: begin
                mask_mode_s = MM_VICTIM;
                ss1_s       = victim_s;
                ss1_valid_s = 1'b1;
            end
            default: begin
                move_valid_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            victim_r     <= 6'd0;
            attacker_r   <= 6'd0;
            wait_cnt_r   <= 3'd0;
            wtm_r        <= 1'b0;
            move_count_r <= 8'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            move_valid_r <= 1'b0;
            move_from_r  <= 6'd0;
            move_to_r    <= 6'd0;
            state_mode_r <= SM_NOP;
            mask_mode_r  <= MM_NONE;
            ss1_r        <= 6'd0;
            ss1_valid_r  <= 1'b0;
            ss2_r        <= 6'd0;
            ss2_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            victim_r     <= victim_s;
            attacker_r   <= attacker_s;
            wait_cnt_r   <= wait_cnt_s;
            wtm_r        <= wtm_s;
            move_count_r <= move_count_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            move_valid_r <= move_valid_s;
            move_from_r  <= move_from_s;
            move_to_r    <= move_to_s;
            state_mode_r <= state_mode_s;
            mask_mode_r  <= mask_mode_s;
            ss1_r        <= ss1_s;
            ss1_valid_r  <= ss1_valid_s;
            ss2_r        <= ss2_s;
            ss2_valid_r  <= ss2_valid_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign move_valid = move_valid_r;
    assign move_from  = move_from_r;
    assign move_to    = move_to_r;
    assign move_count = move_count_r;
    assign state_mode = state_mode_r;
    assign mask_mode  = mask_mode_r;
    assign wtm        = wtm_r;
    assign write_bus  = 4'd0;
    assign ss1        = ss1_r;
    assign ss1_valid  = ss1_valid_r;
    assign ss2        = ss2_r;
    assign ss2_valid  = ss2_valid_r;

endmodule

// File: tb/tb_movegen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_movegen_ctrl
//
// Bench for movegen_ctrl. It contains a behavioural board model with the
// same latency (BOARD_LAT) and its own victim/attacker masks.
//
// Board scenarios:
//   0  empty board
//   1  victim 27, attacked by 12 and 36
//   2  victims 0..9, each attacked by squares 10..39 (300 moves in total)
//
// Full passes come from a vector table. Stall, abort, start+abort and
// async-reset cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_movegen_ctrl;

    localparam int L = 2;
    localparam logic [2:0] SM_VICTIM   = 3'd1;
    localparam logic [2:0] SM_ATTACKER = 3'd2;
    localparam logic [1:0] MM_CLEAR    = 2'd1;
    localparam logic [1:0] MM_VICTIM   = 2'd2;
    localparam logic [1:0] MM_ATTACKER = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       side = 1'b0;
    logic       abort = 1'b0;
    logic       move_ready = 1'b1;
    logic [6:0] board_data = 7'd0;
    logic       busy, done, move_valid, wtm, ss1_valid, ss2_valid;
    logic [5:0] move_from, move_to, ss1, ss2;
    logic [7:0] move_count;
    logic [2:0] state_mode;
    logic [1:0] mask_mode;
    logic [3:0] write_bus;

    movegen_ctrl #(.BOARD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .side(side), .abort(abort),
        .busy(busy), .done(done), .move_valid(move_valid), .move_ready(move_ready),
        .move_from(move_from), .move_to(move_to), .move_count(move_count),
        .state_mode(state_mode), .mask_mode(mask_mode), .wtm(wtm),
        .write_bus(write_bus), .ss1(ss1), .ss1_valid(ss1_valid), .ss2(ss2),
        .ss2_valid(ss2_valid), .board_data(board_data)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int scen = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_n = 0;
    int valid_seen = 0;
    int mv_from_q[$];
    int mv_to_q[$];
    int ma_ss1_q[$];
    int ma_ss2_q[$];
    int mvv_q[$];
    int cmd_q[$];
    logic [63:0] vmask;
    logic [63:0] amask [0:63];
    logic [6:0]  pipe [0:L];
    logic [6:0]  res;

    function automatic bit is_victim(input int s, input int v);
        if (s == 1) return (v == 27);
        else if (s == 2) return (v < 10);
        else return 1'b0;
    endfunction

    function automatic bit attacks(input int s, input int a, input int v);
        if (s == 1) return (v == 27) && (a == 12 || a == 36);
        else if (s == 2) return (v < 10) && (a >= 10) && (a < 40);
        else return 1'b0;
    endfunction

    // Board model plus event monitor. It samples mid-cycle. A result
    // computed in cycle N appears on board_data in cycle N+L.
    always @(negedge clk) begin
        res = 7'd0;
        if (state_mode == SM_VICTIM) begin
            for (int v = 0; v < 64; v++)
                if (!res[6] && is_victim(scen, v) && !vmask[v]) res = {1'b1, 6'(v)};
        end else if (state_mode == SM_ATTACKER && ss1_valid) begin
            for (int a = 0; a < 64; a++)
                if (!res[6] && attacks(scen, a, int'(ss1)) && !amask[ss1][a]) res = {1'b1, 6'(a)};
        end
        case (mask_mode)
            MM_CLEAR: begin
                vmask = 64'd0;
                for (int i = 0; i < 64; i++) amask[i] = 64'd0;
            end
            MM_VICTIM:   vmask[ss1] = 1'b1;
            MM_ATTACKER: amask[ss1][ss2] = 1'b1;
            default: ;
        endcase
        for (int k = L; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = res;
        board_data = pipe[L];

        if (rst_n) begin
            if (move_valid) valid_seen++;
            if (move_valid && move_ready && !abort) begin
                mv_from_q.push_back(int'(move_from));
                mv_to_q.push_back(int'(move_to));
            end
            if (mask_mode == MM_ATTACKER) begin
                ma_ss1_q.push_back(int'(ss1));
                ma_ss2_q.push_back(int'(ss2));
            end
            if (mask_mode == MM_VICTIM) mvv_q.push_back(int'(ss1));
            if ((state_mode != 3'd0 || mask_mode != 2'd0) && cmd_q.size() < 2)
                cmd_q.push_back(int'(mask_mode) * 8 + int'(state_mode));
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (start && !busy && !abort) start_cyc = cyc;
        end
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        mv_from_q.delete(); mv_to_q.delete(); ma_ss1_q.delete();
        ma_ss2_q.delete(); mvv_q.delete(); cmd_q.delete();
        done_n = 0;
        valid_seen = 0;
    endtask

    task automatic pulse_start(input logic side_i);
        @(posedge clk); #1;
        start = 1'b1;
        side = side_i;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && done_n == 0; i++) @(posedge clk);
        check("pass_completed", done_n, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   scen;
        logic side;
        int   exp_moves;
        int   exp_count;
        int   exp_dcyc;
        int   exp_nmv;
    } vec_t;
    vec_t vt [0:2];

    task automatic run_vec(input int i);
        scen = vt[i].scen;
        clear_log();
        move_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        side = vt[i].side;
        @(negedge clk);
        check("busy_low_in_start_cycle", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        wait_done();
        check("done_single_pulse", done_n, 1);
        check("move_count", int'(move_count), vt[i].exp_count);
        check("moves_accepted", mv_from_q.size(), vt[i].exp_moves);
        check("valid_cycles", valid_seen, vt[i].exp_moves);
        check("done_latency", done_cyc - start_cyc, vt[i].exp_dcyc);
        check("victim_masks", mvv_q.size(), vt[i].exp_nmv);
        check("busy_after_done", int'(busy), 0);
        check("wtm_latched", int'(wtm), int'(vt[i].side));
        check("write_bus", int'(write_bus), 0);
        if (vt[i].scen == 0 && cmd_q.size() == 2) begin
            check("cmd0_clear", cmd_q[0], int'(MM_CLEAR) * 8);
            check("cmd1_victim", cmd_q[1], int'(SM_VICTIM));
        end
        if (vt[i].scen == 1 && mv_from_q.size() == 2 && ma_ss2_q.size() == 2 && mvv_q.size() == 1) begin
            check("move0_from", mv_from_q[0], 12);
            check("move0_to", mv_to_q[0], 27);
            check("move1_from", mv_from_q[1], 36);
            check("move1_to", mv_to_q[1], 27);
            check("mask_a0_ss1", ma_ss1_q[0], 27);
            check("mask_a0_ss2", ma_ss2_q[0], 12);
            check("mask_a1_ss2", ma_ss2_q[1], 36);
            check("mask_v_ss1", mvv_q[0], 27);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        vt[0] = '{scen: 0, side: 1'b0, exp_moves: 0,   exp_count: 0,   exp_dcyc: 5,    exp_nmv: 0};
        vt[1] = '{scen: 1, side: 1'b1, exp_moves: 2,   exp_count: 2,   exp_dcyc: 22,   exp_nmv: 1};
        vt[2] = '{scen: 2, side: 1'b0, exp_moves: 300, exp_count: 255, exp_dcyc: 1575, exp_nmv: 10};
        vmask = 64'd0;
        for (int i = 0; i < 64; i++) amask[i] = 64'd0;
        for (int k = 0; k <= L; k++) pipe[k] = 7'd0;

        // Outputs during reset.
        #1;
        check("reset_outputs_zero", int'(|{busy, done, move_valid, move_from, move_to, move_count,
              state_mode, mask_mode, wtm, write_bus, ss1, ss1_valid, ss2, ss2_valid}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_vec(i);

        // Stall for 5 cycles in EMIT. A stray start arrives while busy.
        scen = 1;
        clear_log();
        move_ready = 1'b0;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && !move_valid; i++) begin
            @(posedge clk); #1;
        end
        check("stall_valid_reached", int'(move_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(move_valid), 1);
            check("stall_from", int'(move_from), 12);
            check("stall_to", int'(move_to), 27);
            check("stall_count", int'(move_count), 0);
            start = (i == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        move_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_count_after_ready", int'(move_count), 1);
        check("stall_valid_dropped", int'(move_valid), 0);
        check("stall_mask_attacker", int'(mask_mode), int'(MM_ATTACKER));
        wait_done();
        check("stall_final_count", int'(move_count), 2);
        check("stall_done_once", done_n, 1);

        // Abort on the handshake cycle.
        scen = 1;
        clear_log();
        pulse_start(1'b0);
        for (int i = 0; i < 50 && !move_valid; i++) begin
            @(posedge clk); #1;
        end
        check("abort_valid_reached", int'(move_valid), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(move_valid), 0);
        check("abort_count", int'(move_count), 0);
        check("abort_state_mode", int'(state_mode), 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_n, 0);
        check("abort_stays_idle", int'(busy), 0);

        // start together with abort in idle.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_mask", int'(mask_mode), 0);

        // Async reset during AWAIT, then a full pass afterwards.
        scen = 1;
        clear_log();
        pulse_start(1'b1);
        for (int i = 0; i < 50 && state_mode != SM_ATTACKER; i++) begin
            @(posedge clk); #1;
        end
        check("reach_attack", int'(state_mode), int'(SM_ATTACKER));
        @(posedge clk); #2;
        check("await_busy", int'(busy), 1);
        check("await_wtm", int'(wtm), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_wtm", int'(wtm), 0);
        check("async_rst_all_zero", int'(|{busy, done, move_valid, move_from, move_to, move_count,
              state_mode, mask_mode, wtm, write_bus, ss1, ss1_valid, ss2, ss2_valid}), 0);
        @(posedge clk); #1;
        check("rst_no_done", done_n, 0);
        rst_n = 1'b1;
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got time limit, expected finish");
        $fatal(1, "timeout");
    end

endmodule
